// File: rtl/normalize_round_pipe_if.sv
// Bus bundle for normalize_round_pipe: aligned-sum input side and float result side.
// master drives the sum and consumes the result; slave is the normalizer.
interface normalize_round_pipe_if #(
  parameter int unsigned SUM_W  = 19,
  parameter int unsigned FRAC_W = 4
);
  logic              i_valid;
  logic [SUM_W-1:0]  i_sum;
  logic [5:0]        i_max_exp;
  logic [4:0]        i_Q_frac;

  logic              o_valid;
  logic              o_sign;
  logic [5:0]        o_exp;
  logic [FRAC_W-1:0] o_frac;
  logic              o_zero;
  logic              o_ovf;
  logic              o_unf;
  logic [4:0]        o_Q_frac;

  modport master (
    output i_valid, i_sum, i_max_exp, i_Q_frac,
    input  o_valid, o_sign, o_exp, o_frac, o_zero, o_ovf, o_unf, o_Q_frac
  );

  modport slave (
    input  i_valid, i_sum, i_max_exp, i_Q_frac,
    output o_valid, o_sign, o_exp, o_frac, o_zero, o_ovf, o_unf, o_Q_frac
  );
endinterface

// File: rtl/normalize_round_pipe.sv
// Two-stage normalizer: two's-complement aligned sum -> sign / biased exponent / RNE fraction.
// Stage 1 takes the magnitude; stage 2 finds the leading one, shifts, rounds and classifies.
module normalize_round_pipe #(
  parameter int unsigned SUM_W  = 19,
  parameter int unsigned FRAC_W = 4
) (
  input logic                   i_clk,
  input logic                   i_rst_n,
  normalize_round_pipe_if.slave bus
);

  localparam int unsigned PW    = $clog2(SUM_W);
  localparam int unsigned BinPt = 13;  // bit of i_sum with weight 1.0

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic             s1_sign_q, s1_sign_d;
  logic [SUM_W-1:0] s1_mag_q, s1_mag_d;
  logic [5:0]       s1_max_exp_q, s1_max_exp_d;
  logic [4:0]       s1_q_frac_q, s1_q_frac_d;

  // Stage 2 (output) state
  logic              o_valid_q, o_valid_d;
  logic              o_sign_q, o_sign_d;
  logic [5:0]        o_exp_q, o_exp_d;
  logic [FRAC_W-1:0] o_frac_q, o_frac_d;
  logic              o_zero_q, o_zero_d;
  logic              o_ovf_q, o_ovf_d;
  logic              o_unf_q, o_unf_d;
  logic [4:0]        o_q_frac_q, o_q_frac_d;

  always_comb begin
    s1_valid_d   = bus.i_valid;
    s1_sign_d    = s1_sign_q;
    s1_mag_d     = s1_mag_q;
    s1_max_exp_d = s1_max_exp_q;
    s1_q_frac_d  = s1_q_frac_q;
    if (bus.i_valid) begin
      s1_sign_d    = bus.i_sum[SUM_W-1];
      // Most-negative input negates to itself, which is the correct unsigned magnitude.
      s1_mag_d     = bus.i_sum[SUM_W-1] ? (~bus.i_sum + 1'b1) : bus.i_sum;
      s1_max_exp_d = bus.i_max_exp;
      s1_q_frac_d  = bus.i_Q_frac;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_mag_q     <= '0;
      s1_max_exp_q <= '0;
      s1_q_frac_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_mag_q     <= s1_mag_d;
      s1_max_exp_q <= s1_max_exp_d;
      s1_q_frac_q  <= s1_q_frac_d;
    end
  end

  // Leading-one position, normalizing shift and RNE rounding.
  logic [PW-1:0]     lead_pos;
  logic [PW-1:0]     shift_amt;
  logic [SUM_W-2:0]  norm_lo;  // bits below the (implicit) leading one after the shift
  logic [FRAC_W-1:0] frac_raw;
  logic              guard;
  logic              sticky;
  logic              round_up;
  logic [FRAC_W:0]   frac_sum;
  logic              carry;
  logic [7:0]        exp_raw;
  logic              mag_zero;
  logic              exp_ovf;
  logic              exp_unf;

  always_comb begin
    lead_pos = '0;
    for (int unsigned i = 0; i < SUM_W; i++) begin
      if (s1_mag_q[i]) lead_pos = PW'(i);
    end
    shift_amt = PW'(SUM_W - 1) - lead_pos;
    norm_lo   = (SUM_W-1)'(s1_mag_q << shift_amt);
    frac_raw  = norm_lo[SUM_W-2 -: FRAC_W];
    guard     = norm_lo[SUM_W-FRAC_W-2];
    sticky    = |norm_lo[SUM_W-FRAC_W-3:0];
    round_up  = guard & (sticky | frac_raw[0]);
    frac_sum  = {1'b0, frac_raw} + {{FRAC_W{1'b0}}, round_up};
    carry     = frac_sum[FRAC_W];
    exp_raw   = 8'(s1_max_exp_q) + 8'(lead_pos) + 8'(carry) - 8'(BinPt);
    mag_zero  = (s1_mag_q == '0);
    exp_ovf   = $signed(exp_raw) > 8'sd63;
    exp_unf   = $signed(exp_raw) < 8'sd1;
  end

  always_comb begin
    o_valid_d  = s1_valid_q;
    o_sign_d   = o_sign_q;
    o_exp_d    = o_exp_q;
    o_frac_d   = o_frac_q;
    o_zero_d   = o_zero_q;
    o_ovf_d    = o_ovf_q;
    o_unf_d    = o_unf_q;
    o_q_frac_d = o_q_frac_q;
    if (s1_valid_q) begin
      o_q_frac_d = s1_q_frac_q;
      o_zero_d   = 1'b0;
      o_ovf_d    = 1'b0;
      o_unf_d    = 1'b0;
      if (mag_zero) begin
        o_zero_d = 1'b1;
        o_sign_d = 1'b0;
        o_exp_d  = '0;
        o_frac_d = '0;
      end else if (exp_ovf) begin
        o_ovf_d  = 1'b1;
        o_sign_d = s1_sign_q;
        o_exp_d  = 6'd63;
        o_frac_d = '1;
      end else if (exp_unf) begin
        o_unf_d  = 1'b1;
        o_sign_d = 1'b0;
        o_exp_d  = '0;
        o_frac_d = '0;
      end else begin
        o_sign_d = s1_sign_q;
        o_exp_d  = exp_raw[5:0];
        o_frac_d = frac_sum[FRAC_W-1:0];  // carry-out leaves these at zero
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid_q  <= 1'b0;
      o_sign_q   <= 1'b0;
      o_exp_q    <= '0;
      o_frac_q   <= '0;
      o_zero_q   <= 1'b0;
      o_ovf_q    <= 1'b0;
      o_unf_q    <= 1'b0;
      o_q_frac_q <= '0;
    end else begin
      o_valid_q  <= o_valid_d;
      o_sign_q   <= o_sign_d;
      o_exp_q    <= o_exp_d;
      o_frac_q   <= o_frac_d;
      o_zero_q   <= o_zero_d;
      o_ovf_q    <= o_ovf_d;
      o_unf_q    <= o_unf_d;
      o_q_frac_q <= o_q_frac_d;
    end
  end

  assign bus.o_valid  = o_valid_q;
  assign bus.o_sign   = o_sign_q;
  assign bus.o_exp    = o_exp_q;
  assign bus.o_frac   = o_frac_q;
  assign bus.o_zero   = o_zero_q;
  assign bus.o_ovf    = o_ovf_q;
  assign bus.o_unf    = o_unf_q;
  assign bus.o_Q_frac = o_q_frac_q;

endmodule
